i2c_regfile_target: RTL and testbench

I2C_REGFILE_TARGET -- requirements
Module: i2c_regfile_target

---
 rtl/i2c_regfile_target.sv | 195 +++++++++++++++++++
 tb/tb_i2c_regfile_target.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile_target.sv
// I2C target exposing an 8-bit register file: write pointer + data bytes, auto-incrementing reads.
// Optional macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizers.
module i2c_regfile_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  localparam int        PW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  input  logic [PW-1:0] host_raddr,
  output logic [7:0]    host_rdata,
  output logic          wr_pulse,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t        state;
  logic [1:0]    scl_sync, sda_sync;
  logic          scl_f, sda_f;
  logic          scl_q, sda_q;
  logic [2:0]    settle_cnt;
  logic          settled;
  logic [7:0]    regs [NUM_REGS];
  logic [PW-1:0] ptr;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          sda_oe;
  logic [7:0]    rx_byte;
  logic [2:0]    tx_idx;
  logic          scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam logic [2:0] SETTLE = 3'd5;
  logic [2:0] scl_hist, sda_hist;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end

  assign scl_f = maj3(scl_hist);
  assign sda_f = maj3(sda_hist);
`else
  localparam logic [2:0] SETTLE = 3'd3;
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  // Reset preloads the pipeline with ones; edges are ignored until real bus values have flushed
  // through, so a bus held mid-bit across reset cannot fake a start or stop.
  assign settled   = (settle_cnt == SETTLE);
  assign scl_rise  = settled &  scl_f & ~scl_q;
  assign scl_fall  = settled & ~scl_f &  scl_q;
  assign start_det = settled &  scl_f &  scl_q &  sda_q & ~sda_f;
  assign stop_det  = settled &  scl_f &  scl_q & ~sda_q &  sda_f;
  assign rx_byte   = {shreg, sda_f};
  assign tx_idx    = 3'd7 - bit_cnt;

  assign sda  = sda_oe ? 1'b0 : 1'bz;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      settle_cnt <= 3'd0;
      sda_oe     <= 1'b0;
      ptr        <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      scl_q    <= scl_f;
      sda_q    <= sda_f;
      wr_pulse <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt + 3'd1;

      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  ADDR:    state <= (rx_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                  PTR: begin
                    ptr   <= rx_byte[PW-1:0];
                    state <= PTR_ACK;
                  end
                  default: begin
                    regs[ptr] <= rx_byte;
                    wr_pulse  <= 1'b1;
                    wr_addr   <= ptr;
                    wr_data   <= rx_byte;
                    ptr       <= ptr + 1'b1;
                    state     <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // First fall after the byte starts the ACK; the second ends it. shreg[0] holds R/W.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (shreg[0]) begin
                state  <= RDATA;
                sda_oe <= ~regs[ptr][7];
              end else begin
                state  <= PTR;
                sda_oe <= 1'b0;
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                state  <= WDATA;
                sda_oe <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RDATA_ACK;
            end else if (scl_fall) begin
              sda_oe <= ~regs[ptr][tx_idx];
            end
          end
          RDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end else if (scl_rise) begin
              if (!sda_f) begin
                ptr   <= ptr + 1'b1;
                state <= RDATA;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) host_rdata <= 8'h00;
    else     host_rdata <= regs[host_raddr];
  end

endmodule

// File: tb/tb_i2c_regfile_target.sv
// Bench for i2c_regfile_target: bit-banged I2C master, array model of the register file.
module tb_i2c_regfile_target;
  localparam logic [6:0] TGT = 7'h50;
  localparam int N  = 16;
  localparam int PW = 4;
  localparam int Q  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl = 1'b1;
  logic          sda_low = 1'b0;
  wire           sda_bus;
  logic [PW-1:0] host_raddr = '0;
  logic [7:0]    host_rdata;
  logic          wr_pulse;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  always #5 clk = ~clk;

  i2c_regfile_target #(.SLAVE_ADDR(TGT), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
    .host_raddr(host_raddr), .host_rdata(host_rdata),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]    model_regs [N];
  int            model_ptr;
  logic [7:0]    tx_buf [8];
  logic [7:0]    rx_buf [8];
  logic [PW+7:0] wr_q[$];
  logic [PW+7:0] exp_wr[$];
  logic [7:0]    rd_at_q[$];
  logic [7:0]    rd_after_q[$];
  logic          prev_wr = 1'b0;

  // Records every cycle wr_pulse is high, plus host_rdata on that cycle and the next.
  always @(negedge clk) begin
    if (prev_wr) rd_after_q.push_back(host_rdata);
    prev_wr = wr_pulse;
    if (wr_pulse) begin
      wr_q.push_back({wr_addr, wr_data});
      rd_at_q.push_back(host_rdata);
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b1; wait_q(); scl = 1'b0;
  endtask

  task automatic bus_restart();
    wait_q(); sda_low = 1'b0; wait_q(); scl = 1'b1; wait_q(); sda_low = 1'b1; wait_q(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); sda_low = 1'b1; wait_q(); scl = 1'b1; wait_q(); sda_low = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b);
    wait_q(); sda_low = ~b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_q(); sda_low = 1'b0; wait_q(); scl = 1'b1; wait_q(); b = sda_bus; wait_q(); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(b);
    ack = (b === 1'b0);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    send_bit(~ack);
  endtask

  task automatic host_read(input int idx, output logic [7:0] v);
    host_raddr = PW'(idx);
    @(negedge clk);
    v = host_rdata;
  endtask

  task automatic clear_mon();
    wr_q.delete(); exp_wr.delete(); rd_at_q.delete(); rd_after_q.delete();
  endtask

  task automatic bus_write(input logic [7:0] pbyte, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    send_byte({TGT, 1'b0}, a); acks += int'(a);
    send_byte(pbyte, a);       acks += int'(a);
    for (int i = 0; i < n; i++) begin send_byte(tx_buf[i], a); acks += int'(a); end
    bus_stop();
  endtask

  task automatic bus_read_ptr(input logic [7:0] pbyte, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    send_byte({TGT, 1'b0}, a); acks += int'(a);
    send_byte(pbyte, a);       acks += int'(a);
    bus_restart();
    send_byte({TGT, 1'b1}, a); acks += int'(a);
    for (int i = 0; i < n; i++) recv_byte(rx_buf[i], i != n - 1);
    bus_stop();
  endtask

  // Reference model: pointer write then data bytes land at consecutive indices modulo N.
  task automatic model_write(input logic [7:0] pbyte, input int n);
    int idx;
    idx = int'(pbyte) % N;
    for (int i = 0; i < n; i++) begin
      model_regs[(idx + i) % N] = tx_buf[i];
      exp_wr.push_back({PW'((idx + i) % N), tx_buf[i]});
    end
    model_ptr = (idx + n) % N;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0; @(negedge clk);
    model_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_rdata: got %h want 00", host_rdata); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
    for (int i = 0; i < N; i++) begin
      host_read(i, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h want 00", i, v); end
    end
  endtask

  task automatic check_writes(input string tag);
    checks++;
    if (wr_q.size() != exp_wr.size()) begin
      errors++; $display("FAIL %s_wr_count: got %0d want %0d", tag, wr_q.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        checks++;
        if (wr_q[i] !== exp_wr[i]) begin
          errors++; $display("FAIL %s_wr%0d: got %h want %h", tag, i, wr_q[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic check_regfile(input string tag);
    logic [7:0] v;
    for (int i = 0; i < N; i++) begin
      host_read(i, v);
      checks++;
      if (v !== model_regs[i]) begin errors++; $display("FAIL %s_reg%0d: got %h want %h", tag, i, v, model_regs[i]); end
    end
  endtask

  task automatic test_basic_write();
    int acks; logic [7:0] v;
    clear_mon();
    tx_buf[0] = 8'h5A; tx_buf[1] = 8'hC3;
    bus_write(8'h03, 2, acks);
    model_write(8'h03, 2);
    checks++; if (acks != 4) begin errors++; $display("FAIL basic_acks: got %0d want 4", acks); end
    checks++; if (exp_wr[1] !== {4'd4, 8'hC3}) begin errors++; $display("FAIL basic_model: got %h want 4c3", exp_wr[1]); end
    check_writes("basic");
    host_read(4, v);
    checks++; if (v !== 8'hC3) begin errors++; $display("FAIL basic_host4: got %h want c3", v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
  endtask

  task automatic test_combined_read();
    logic a; int acks;
    acks = 0;
    bus_start();
    send_byte({TGT, 1'b0}, a); acks += int'(a);
    send_byte(8'h02, a);       acks += int'(a);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL comb_busy_mid: got %b want 1", busy); end
    bus_restart();
    send_byte({TGT, 1'b1}, a); acks += int'(a);
    recv_byte(rx_buf[0], 1'b1);
    recv_byte(rx_buf[1], 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL comb_busy_nack: got %b want 0", busy); end
    bus_stop();
    model_ptr = 3;
    checks++; if (acks != 3) begin errors++; $display("FAIL comb_acks: got %0d want 3", acks); end
    checks++; if (rx_buf[0] !== model_regs[2]) begin errors++; $display("FAIL comb_byte0: got %h want %h", rx_buf[0], model_regs[2]); end
    checks++; if (rx_buf[1] !== model_regs[3]) begin errors++; $display("FAIL comb_byte1: got %h want %h", rx_buf[1], model_regs[3]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL comb_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_ptr_kept();
    logic a;
    bus_start();
    send_byte({TGT, 1'b1}, a);
    recv_byte(rx_buf[0], 1'b1);
    recv_byte(rx_buf[1], 1'b0);
    bus_stop();
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL kept_ack: got %b want 1", a); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rx_buf[i] !== model_regs[(model_ptr + i) % N]) begin
        errors++; $display("FAIL kept_byte%0d: got %h want %h", i, rx_buf[i], model_regs[(model_ptr + i) % N]);
      end
    end
    model_ptr = (model_ptr + 1) % N;
  endtask

  task automatic test_addr_mismatch();
    logic a; logic [6:0] ad;
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      ad = (k == 0) ? 7'h52 : 7'($urandom_range(0, 127));
      if (ad == TGT) ad = ad ^ 7'h01;
      bus_start();
      send_byte({ad, 1'b0}, a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL nomatch_ack%0d: got %b want 0 addr %h", k, a, ad); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nomatch_busy%0d: got %b want 0", k, busy); end
      send_byte(8'($urandom), a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL nomatch_data_ack%0d: got %b want 0", k, a); end
      bus_stop();
    end
    check_writes("nomatch");
    check_regfile("nomatch");
  endtask

  task automatic test_wrap();
    int acks;
    clear_mon();
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22;
    bus_write(8'h0F, 2, acks);
    model_write(8'h0F, 2);
    checks++; if (acks != 4) begin errors++; $display("FAIL wrap_acks: got %0d want 4", acks); end
    checks++; if (model_regs[0] !== 8'h22) begin errors++; $display("FAIL wrap_model: got %h want 22", model_regs[0]); end
    check_writes("wrap");
    check_regfile("wrap");
  endtask

  task automatic test_random();
    int acks, n; logic [7:0] pb;
    for (int it = 0; it < 5; it++) begin
      clear_mon();
      pb = 8'($urandom);
      n  = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      bus_write(pb, n, acks);
      model_write(pb, n);
      checks++; if (acks != n + 2) begin errors++; $display("FAIL rand%0d_acks: got %0d want %0d", it, acks, n + 2); end
      check_writes("rand");
      pb = 8'($urandom);
      n  = $urandom_range(1, 4);
      bus_read_ptr(pb, n, acks);
      checks++; if (acks != 3) begin errors++; $display("FAIL rand%0d_racks: got %0d want 3", it, acks); end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx_buf[i] !== model_regs[(int'(pb) + i) % N]) begin
          errors++; $display("FAIL rand%0d_rd%0d: got %h want %h", it, i, rx_buf[i], model_regs[(int'(pb) + i) % N]);
        end
      end
      model_ptr = (int'(pb) + n - 1) % N;
    end
    check_regfile("rand");
  endtask

  task automatic test_same_cycle();
    int acks, p; logic [7:0] old_v;
    clear_mon();
    p = $urandom_range(0, N - 1);
    old_v = model_regs[p];
    tx_buf[0] = ~old_v;
    host_raddr = PW'(p);
    bus_write(8'(p), 1, acks);
    model_write(8'(p), 1);
    checks++; if (acks != 3) begin errors++; $display("FAIL same_acks: got %0d want 3", acks); end
    checks++;
    if (rd_at_q.size() != 1 || rd_after_q.size() != 1) begin
      errors++; $display("FAIL same_count: got %0d/%0d want 1/1", rd_at_q.size(), rd_after_q.size());
    end else begin
      if (rd_at_q[0] !== old_v) begin errors++; $display("FAIL same_old: got %h want %h", rd_at_q[0], old_v); end
      checks++;
      if (rd_after_q[0] !== tx_buf[0]) begin errors++; $display("FAIL same_new: got %h want %h", rd_after_q[0], tx_buf[0]); end
    end
  endtask

  task automatic test_rst_mid();
    logic a; int acks; logic [7:0] d;
    d = 8'hA6;
    bus_start();
    send_byte({TGT, 1'b0}, a);
    send_byte(8'h05, a);
    for (int i = 7; i >= 4; i--) send_bit(d[i]);
    wait_q(); sda_low = ~d[3]; wait_q(); scl = 1'b1; wait_q();
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    model_reset();
    checks++; if (sda_bus !== 1'b0) begin errors++; $display("FAIL rstmid_line: got %b want 0", sda_bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    check_regfile("rstmid");
    wait_q(); scl = 1'b0; wait_q(); sda_low = 1'b0; wait_q(); scl = 1'b1; wait_q();
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rstmid_sda: got %b want 1", sda_bus); end
    clear_mon();
    tx_buf[0] = 8'($urandom);
    bus_write(8'h09, 1, acks);
    model_write(8'h09, 1);
    checks++; if (acks != 3) begin errors++; $display("FAIL rstmid_acks: got %0d want 3", acks); end
    check_writes("rstmid");
    check_regfile("rstmid_after");
  endtask

  task automatic test_glitch();
    logic a; logic [7:0] d; int p;
    clear_mon();
    d = 8'($urandom);
    p = $urandom_range(0, N - 1);
    bus_start();
    send_byte({TGT, 1'b0}, a);
    send_byte(8'(p), a);
    for (int i = 7; i >= 5; i--) send_bit(d[i]);
    wait_q(); sda_low = ~d[4];
    repeat (3) @(negedge clk); scl = 1'b1; @(negedge clk); scl = 1'b0;
    repeat (Q - 4) @(negedge clk); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0;
    for (int i = 3; i >= 0; i--) send_bit(d[i]);
    read_bit(a);
    bus_stop();
`ifdef I2C_TGT_GLITCH_FILTER_EN
    tx_buf[0] = d;
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL glitch_ack: line %b want 0", a); end
`else
    tx_buf[0] = {d[7:4], d[4:1]};
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL glitch_ack: line %b want 1", a); end
`endif
    model_write(8'(p), 1);
    check_writes("glitch");
    check_regfile("glitch");
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_combined_read();
    test_ptr_kept();
    test_addr_mismatch();
    test_wrap();
    test_random();
    test_same_cycle();
    test_rst_mid();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
